// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM state codes,
// ALU-control op codes, opcode constants and datapath mux selects. The
// ALU-control block imports the same package so both agree on alu_op.
package mips_multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_R_EX    = 4'd6,
        S_R_WB    = 4'd7,
        S_BRANCH  = 4'd8,
        S_I_EX    = 4'd9,
        S_I_WB    = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    // alu_op: what ALU control should make the ALU do
    localparam logic [2:0] ALU_OP_FUNCT = 3'b000;  // decode from funct/opcode
    localparam logic [2:0] ALU_OP_SUB   = 3'b010;  // branch compare
    localparam logic [2:0] ALU_OP_ADD   = 3'b100;  // address / PC arithmetic

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // State entered after DECODE for a given opcode; FETCH marks an
    // unsupported opcode.
    function automatic state_t decode_dispatch(input logic [5:0] opcode);
        case (opcode)
            OP_LW, OP_SW:                               return S_MEM_ADR;
            OP_RTYPE:                                   return S_R_EX;
            OP_BEQ, OP_BNE:                             return S_BRANCH;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: return S_I_EX;
            OP_J:                                       return S_JUMP;
            default:                                    return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM (Moore). Outputs are decoded from the
// current state; pc_en additionally follows zero in BRANCH, and FETCH
// strobes ir_write/pc_en only in the cycle memory returns the word.
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic       pc_en,
    output logic       f_sel,
    output logic       illegal,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic [3:0] state
);

    state_t r_state;
    state_t w_next_state;

    // Next-state selection from current state, opcode and memory handshake
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:   w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:  w_next_state = decode_dispatch(opcode);
            S_MEM_ADR: w_next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  w_next_state = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:  w_next_state = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EX:    w_next_state = S_R_WB;
            S_I_EX:    w_next_state = S_I_WB;
            default:   w_next_state = S_FETCH;  // WB/BRANCH/JUMP and unused codes
        endcase
    end

    // State register; synchronous reset wins over any pending transition
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next_state;
    end

    // Output decoder; everything is held low while reset is asserted
    always_comb begin
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        pc_en      = 1'b0;
        f_sel      = 1'b0;
        illegal    = 1'b0;
        alu_src_b  = SRC_B_REG;
        pc_src     = PC_SRC_ALU;
        alu_op     = ALU_OP_FUNCT;
        state      = 4'd0;
        if (!rst) begin
            state = r_state;
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    alu_op    = ALU_OP_ADD;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = SRC_B_IMM_SH2;  // branch target precompute
                    alu_op    = ALU_OP_ADD;
                    illegal   = (decode_dispatch(opcode) == S_FETCH);
                end
                S_MEM_ADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALU_OP_ADD;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_R_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_REG;
                    alu_op    = ALU_OP_FUNCT;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_REG;
                    alu_op    = ALU_OP_SUB;
                    pc_src    = PC_SRC_ALUOUT;
                    pc_en     = (opcode == OP_BEQ) ? zero : ~zero;
                end
                S_I_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALU_OP_FUNCT;
                    f_sel     = 1'b1;
                end
                S_I_WB: begin
                    reg_write = 1'b1;
                end
                S_JUMP: begin
                    pc_src = PC_SRC_JUMP;
                    pc_en  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 SHALL have ports (name  direction  width  meaning): clk  in  1  sole clock, rising edge; rst  in  1  synchronous, active-high reset.
REQ-002 SHALL have opcode  in  6  instruction[31:26] from the instruction register, stable from DECODE until return to FETCH; zero  in  1  ALU zero flag; mem_ready  in  1  memory access completes this cycle.
REQ-003 SHALL have outputs, each 1 bit: ir_write, mem_read, mem_write, iord (1 = ALUOut address), reg_write, reg_dst (1 = rd), mem_to_reg, alu_src_a (1 = register A), pc_en, f_sel (ALU-control F source: 0 = funct, 1 = opcode), illegal (one-cycle pulse).
REQ-004 SHALL have alu_src_b  out  2  (00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2); pc_src  out  2  (00 ALU, 01 ALUOut, 10 jump target); alu_op  out  3  to ALU control; state  out  4  current state, debug.

Function
REQ-005 SHALL be a Moore FSM; all outputs except pc_en SHALL be decoded from state only; pc_en also depends on zero in BRANCH.
REQ-006 SHALL encode alu_op: 000 decode F (R-type or immediate ALU op), 010 branch compare (subtract), 100 add (address/PC arithmetic).
REQ-007 States/codes: FETCH 0, DECODE 1, MEM_ADR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EX 6, R_WB 7, BRANCH 8, I_EX 9, I_WB 10, JUMP 11; codes 12-15 unused.
REQ-008 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=100, pc_src=00; ir_write=1 and pc_en=1 only in the cycle mem_ready=1; stays in FETCH while mem_ready=0, else to DECODE.
REQ-009 DECODE: alu_src_a=0, alu_src_b=11, alu_op=100 (branch target precompute); next by opcode: 100011/101011 -> MEM_ADR; 000000 -> R_EX; 000100/000101 -> BRANCH; 001000/001010/001100/001101/001110 -> I_EX; 000010 -> JUMP; any other -> FETCH with illegal=1 for that DECODE cycle.
REQ-010 MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=100; -> MEM_RD if opcode=100011, else MEM_WR.
REQ-011 MEM_RD: mem_read=1, iord=1; holds while mem_ready=0; -> MEM_WB when mem_ready=1.
REQ-012 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; -> FETCH.
REQ-013 MEM_WR: mem_write=1, iord=1; holds while mem_ready=0; -> FETCH when mem_ready=1.
REQ-014 R_EX: alu_src_a=1, alu_src_b=00, alu_op=000, f_sel=0; -> R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; -> FETCH.
REQ-015 I_EX: alu_src_a=1, alu_src_b=10, alu_op=000, f_sel=1; -> I_WB. I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; -> FETCH.
REQ-016 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=010, pc_src=01; pc_en = zero when opcode=000100, ~zero when 000101; -> FETCH.
REQ-017 JUMP: pc_src=10, pc_en=1; -> FETCH.
REQ-018 Outputs not listed for a state SHALL be 0 (alu_src_b/pc_src/alu_op = 0).
REQ-019 Cycles per instruction with mem_ready held 1: R/immediate 4, lw 5, sw 4, beq/bne 3, j 3, illegal 2; each memory wait cycle adds exactly one.
REQ-020 Unused state codes SHALL transition to FETCH on the next edge.

Reset
REQ-021 rst high at a rising edge SHALL force state=FETCH, overriding any transition, including mid-wait in MEM_RD/MEM_WR.
REQ-022 While rst is high all outputs SHALL be 0 (state output shows 0); the first cycle after rst falls SHALL be FETCH with mem_read=1.

Structure
REQ-023 State codes, alu_op codes, opcode constants and alu_src_b/pc_src encodings SHALL live in a shared package/include used also by alu_control.
REQ-024 Single module: one next-state process plus one output decoder; no sub-module.

Verification
REQ-025 Reset mid-MEM_RD with mem_ready=0 -> next edge state=0, all outputs 0 during rst, mem_read=1 the cycle after rst falls.
REQ-026 opcode=000000, mem_ready=1 -> states 0,1,6,7,0; alu_op=000 f_sel=0 in R_EX; reg_write=1 reg_dst=1 in R_WB.
REQ-027 opcode=100011, mem_ready low 2 cycles in FETCH and 3 in MEM_RD -> 10-cycle sequence; ir_write/pc_en exactly one pulse in FETCH; reg_write mem_to_reg=1 in MEM_WB.
REQ-028 opcode=000100 zero=1 -> pc_en=1 in BRANCH; opcode=000101 zero=1 -> pc_en=0; alu_op=010 both.
REQ-029 opcode=001101 -> I_EX with alu_op=000 f_sel=1 alu_src_b=10; opcode=000010 -> JUMP with pc_src=10 pc_en=1.
REQ-030 opcode=111111 -> states 0,1,0 with illegal=1 only in DECODE; no reg_write/mem_write asserted.
